// File: rtl/ahb_mtx_pkg.sv
// Shared encodings for the bus-matrix output-stage round-robin arbiter:
// HTRANS/HBURST codes, the arbiter state enum, and the burst-length helper.
package ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Remaining beats after the first beat of a defined-length burst
    localparam logic [3:0] BEATS_LEFT_4  = 4'd3;
    localparam logic [3:0] BEATS_LEFT_8  = 4'd7;
    localparam logic [3:0] BEATS_LEFT_16 = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OWNED  = 2'b01,
        ST_BURST  = 2'b10,
        ST_LOCKED = 2'b11
    } arb_state_t;

    // Beat counter load value for an accepted NONSEQ of the given burst type
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        logic [3:0] n;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  n = BEATS_LEFT_4;
            HBURST_WRAP8,  HBURST_INCR8:  n = BEATS_LEFT_8;
            HBURST_WRAP16, HBURST_INCR16: n = BEATS_LEFT_16;
            default:                      n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_mtx_rr_arb_if.sv
// Bus-side signal bundle of the output-stage arbiter. The master modport is the
// side that drives requests and transfer control; the slave modport is the arbiter.
interface ahb_mtx_rr_arb_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;
    logic [3:0]           beat_cnt;

    modport master (
        output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port, beat_cnt
    );

    modport slave (
        input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port, beat_cnt
    );
endinterface

// File: rtl/ahb_mtx_rr_arb_rr_priority_pick.sv
// Rotating-priority selector: returns the first set request bit searching
// upward from rr_ptr+1 with wrap, plus an any-request flag.
module rr_priority_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PORT_W-1:0]    i_rr_ptr,
    output logic [PORT_W-1:0]    o_winner,
    output logic                 o_any_req
);
    // Walk the ports in rotated order, the previous winner being searched last
    always_comb begin
        int idx;
        logic found;
        o_winner  = '0;
        o_any_req = 1'b0;
        found     = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = (int'(i_rr_ptr) + i) % NUM_PORTS;
            if (!found && i_req[idx]) begin
                found    = 1'b1;
                o_winner = PORT_W'(idx);
            end
        end
        o_any_req = found;
    end
endmodule

// File: rtl/ahb_mtx_rr_arb.sv
// Round-robin output-stage arbiter for a bus-matrix slave port.
// Holds the grant across defined-length bursts and locked sequences, parks on
// the current owner while it keeps the slave selected.
// Optional build macro AHB_MTX_ARB_INCR_HOLD_EN: when defined, an undefined-length
// INCR burst also holds the grant for up to MAX_INCR_HOLD beats.
module ahb_mtx_rr_arb
    import ahb_mtx_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int PORT_W        = $clog2(NUM_PORTS),
    parameter int MAX_INCR_HOLD = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_mtx_rr_arb_if.slave  bus
);
    generate
        if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports
            $error("ahb_mtx_rr_arb: NUM_PORTS must be 2..16");
        end
        if (MAX_INCR_HOLD < 1) begin : g_bad_hold
            $error("ahb_mtx_rr_arb: MAX_INCR_HOLD must be at least 1");
        end
    endgenerate

    arb_state_t        r_state,    w_state_nxt;
    logic [PORT_W-1:0] r_owner,    w_owner_nxt;
    logic [PORT_W-1:0] r_rr_ptr,   w_rr_nxt;
    logic [3:0]        r_beat_cnt, w_cnt_nxt;

    htrans_t           w_trans;
    logic              w_accept;
    logic              w_hold_active;
    logic [PORT_W-1:0] w_winner;
    logic              w_any_req;

    assign w_trans  = htrans_t'(bus.HTRANSM);
    assign w_accept = bus.HREADYM & bus.HSELM &
                      ((w_trans == HTRANS_NONSEQ) || (w_trans == HTRANS_SEQ));

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .i_req     (bus.req_port),
        .i_rr_ptr  (r_rr_ptr),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    // Defined-burst beat counter: NONSEQ loads, SEQ counts down, IDLE clears
    always_comb begin
        w_cnt_nxt = r_beat_cnt;
        if (w_trans == HTRANS_IDLE) begin
            w_cnt_nxt = '0;
        end else if (w_accept && w_trans == HTRANS_NONSEQ) begin
            w_cnt_nxt = burst_beats(bus.HBURSTM);
        end else if (w_accept && w_trans == HTRANS_SEQ && r_beat_cnt != 4'd0) begin
            w_cnt_nxt = r_beat_cnt - 4'd1;
        end
    end

`ifdef AHB_MTX_ARB_INCR_HOLD_EN
    localparam int HOLD_W = $clog2(MAX_INCR_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MAX_INCR_HOLD - 1);

    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;

    // Undefined-length INCR hold counter; any other NONSEQ or IDLE drops the hold
    always_comb begin
        w_hold_nxt = r_hold_cnt;
        if (w_trans == HTRANS_IDLE) begin
            w_hold_nxt = '0;
        end else if (w_accept && w_trans == HTRANS_NONSEQ) begin
            w_hold_nxt = (bus.HBURSTM == HBURST_INCR) ? HOLD_LOAD : '0;
        end else if (w_accept && w_trans == HTRANS_SEQ && r_hold_cnt != '0) begin
            w_hold_nxt = r_hold_cnt - 1'b1;
        end
    end

    assign w_hold_active = (w_hold_nxt != '0);

    // Hold counter register, frozen during wait states
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hold_cnt <= '0;
        end else if (bus.HREADYM) begin
            r_hold_cnt <= w_hold_nxt;
        end
    end
`else
    assign w_hold_active = 1'b0;
`endif

    // State register: owner, round-robin pointer, beat counter and FSM state
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= PORT_W'(NUM_PORTS - 1);
            r_beat_cnt <= '0;
        end else if (bus.HREADYM) begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    // Next-grant decision: lock, then burst hold, then round-robin, then park
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        if (bus.HMASTLOCKM) begin
            w_state_nxt = ST_LOCKED;
        end else if (w_cnt_nxt != 4'd0 || w_hold_active) begin
            w_state_nxt = ST_BURST;
        end else if (w_any_req) begin
            w_state_nxt = ST_OWNED;
            w_owner_nxt = w_winner;
            w_rr_nxt    = w_winner;
        end else if (bus.HSELM) begin
            w_state_nxt = ST_OWNED;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Outputs: mux select is the owner, no_port only while idle
    always_comb begin
        bus.addr_in_port = r_owner;
        bus.no_port      = (r_state == ST_IDLE);
        bus.beat_cnt     = r_beat_cnt;
    end
endmodule

// File: tb/tb_ahb_mtx_rr_arb.sv
// Directed bench for ahb_mtx_rr_arb with a queue scoreboard of expected outputs.
module tb_ahb_mtx_rr_arb;
    import ahb_mtx_pkg::*;

    logic clk;
    logic rst;

    ahb_mtx_rr_arb_if #(.NUM_PORTS(4)) bus ();

    ahb_mtx_rr_arb #(.NUM_PORTS(4), .MAX_INCR_HOLD(16)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] addr;
        logic       nop;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            assert (0) else begin
                errors++;
                $error("FAIL scoreboard_empty observed=output expected=queued_entry");
            end
        end else begin
            e = sb.pop_front();
            checks++;
            assert (bus.addr_in_port === e.addr) else begin
                errors++;
                $error("FAIL %s.addr_in_port observed=%0d expected=%0d", e.tag, bus.addr_in_port, e.addr);
            end
            checks++;
            assert (bus.no_port === e.nop) else begin
                errors++;
                $error("FAIL %s.no_port observed=%0d expected=%0d", e.tag, bus.no_port, e.nop);
            end
            checks++;
            assert (bus.beat_cnt === e.cnt) else begin
                errors++;
                $error("FAIL %s.beat_cnt observed=%0d expected=%0d", e.tag, bus.beat_cnt, e.cnt);
            end
        end
    endtask

    // Drive one cycle of stimulus, queue what the outputs must be after the edge
    task automatic step(input string tag, input logic r, input logic rdy,
                        input logic sel, input logic lock, input logic [3:0] req,
                        input logic [1:0] trans, input logic [2:0] burst,
                        input logic [1:0] ea, input logic en, input logic [3:0] ec);
        exp_t e;
        rst            = r;
        bus.HREADYM    = rdy;
        bus.HSELM      = sel;
        bus.HMASTLOCKM = lock;
        bus.req_port   = req;
        bus.HTRANSM    = trans;
        bus.HBURSTM    = burst;
        e.tag  = tag;
        e.addr = ea;
        e.nop  = en;
        e.cnt  = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with requests present
        step("rst0", 1, 1, 1, 0, 4'b1111, T_NSEQ, HBURST_SINGLE, 2'd0, 1, 4'd0);
        step("rst1", 1, 0, 1, 0, 4'b1111, T_NSEQ, HBURST_INCR8,  2'd0, 1, 4'd0);
        step("rel",  0, 1, 0, 0, 4'b0001, T_IDLE, HBURST_SINGLE, 2'd0, 0, 4'd0);

        // Round-robin across all four requesters
        step("rr1", 0, 1, 1, 0, 4'b1111, T_NSEQ, HBURST_SINGLE, 2'd1, 0, 4'd0);
        step("rr2", 0, 1, 1, 0, 4'b1111, T_NSEQ, HBURST_SINGLE, 2'd2, 0, 4'd0);
        step("rr3", 0, 1, 1, 0, 4'b1111, T_NSEQ, HBURST_SINGLE, 2'd3, 0, 4'd0);
        step("rr0", 0, 1, 1, 0, 4'b1111, T_NSEQ, HBURST_SINGLE, 2'd0, 0, 4'd0);

        // Port 2 takes the bus and runs INCR8 while port 0 keeps requesting
        step("own2",  0, 1, 1, 0, 4'b0100, T_IDLE, HBURST_SINGLE, 2'd2, 0, 4'd0);
        step("b8_ns", 0, 1, 1, 0, 4'b0101, T_NSEQ, HBURST_INCR8,  2'd2, 0, 4'd7);
        for (int i = 1; i <= 7; i++) begin
            if (i == 4) begin
                for (int w = 0; w < 3; w++)
                    step("stall", 0, 0, 1, 0, 4'b1000, T_SEQ, HBURST_INCR8, 2'd2, 0, 4'd4);
            end
            step($sformatf("b8_seq%0d", i), 0, 1, 1, 0, 4'b0101, T_SEQ, HBURST_INCR8,
                 (i == 7) ? 2'd0 : 2'd2, 0, 4'(7 - i));
        end

        // Locked sequence from port 1, then release hands over to port 2
        step("own1", 0, 1, 1, 0, 4'b0010, T_IDLE, HBURST_SINGLE, 2'd1, 0, 4'd0);
        for (int i = 0; i < 4; i++)
            step("lock", 0, 1, 1, 1, 4'b1101, T_NSEQ, HBURST_SINGLE, 2'd1, 0, 4'd0);
        step("unlock", 0, 1, 1, 0, 4'b1101, T_NSEQ, HBURST_SINGLE, 2'd2, 0, 4'd0);

        // Park on owner while selected, then go idle
        step("park0", 0, 1, 1, 0, 4'b0000, T_IDLE, HBURST_SINGLE, 2'd2, 0, 4'd0);
        step("park1", 0, 1, 1, 0, 4'b0000, T_IDLE, HBURST_SINGLE, 2'd2, 0, 4'd0);
        step("idle",  0, 1, 0, 0, 4'b0000, T_IDLE, HBURST_SINGLE, 2'd2, 1, 4'd0);

        // INCR16 interrupted by reset at beat 5 during a wait state
        step("b16_ns", 0, 1, 1, 0, 4'b0001, T_NSEQ, HBURST_INCR16, 2'd2, 0, 4'd15);
        for (int i = 1; i <= 4; i++)
            step("b16_seq", 0, 1, 1, 0, 4'b0001, T_SEQ, HBURST_INCR16, 2'd2, 0, 4'(15 - i));
        step("b16_busy", 0, 1, 1, 0, 4'b0001, T_BUSY, HBURST_INCR16, 2'd2, 0, 4'd11);
        step("mid_rst",  1, 0, 1, 0, 4'b0001, T_SEQ,  HBURST_INCR16, 2'd0, 1, 4'd0);
        step("post_rst", 0, 1, 1, 0, 4'b0011, T_IDLE, HBURST_SINGLE, 2'd0, 0, 4'd0);

        // Undefined-length INCR: re-arbitrates each beat unless the hold is built in
`ifdef AHB_MTX_ARB_INCR_HOLD_EN
        step("incr_ns",  0, 1, 1, 0, 4'b0110, T_NSEQ, HBURST_INCR, 2'd0, 0, 4'd0);
        step("incr_seq", 0, 1, 1, 0, 4'b0110, T_SEQ,  HBURST_INCR, 2'd0, 0, 4'd0);
`else
        step("incr_ns",  0, 1, 1, 0, 4'b0110, T_NSEQ, HBURST_INCR, 2'd1, 0, 4'd0);
        step("incr_seq", 0, 1, 1, 0, 4'b0110, T_SEQ,  HBURST_INCR, 2'd2, 0, 4'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_mtx_rr_arb.md
Name: ahb_mtx_rr_arb

Overview:
Output-stage arbiter for a bus-matrix slave port shared by NUM_PORTS input stages. It uses round-robin priority instead of fixed priority. It holds the grant across defined-length bursts and locked sequences, and parks on the current owner when it is idle-selected. It sits between the input stages and the output-stage address mux, and drives the mux select (addr_in_port) and the no_port indication.

Parameters:
NUM_PORTS, 4, number of requesting input stages (2..16)
PORT_W, $clog2(NUM_PORTS), width of the port index
MAX_INCR_HOLD, 16, beat limit for holding an undefined-length INCR (optional feature only)

Ports:
HCLK  in  1  AHB system clock
HRESET  in  1  synchronous active-high reset
req_port  in  NUM_PORTS  per-input-stage request, bit n = port n
HREADYM  in  1  transfer done on the output port
HSELM  in  1  slave select from the current owner
HTRANSM  in  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
HBURSTM  in  3  burst type
HMASTLOCKM  in  1  locked transfer
addr_in_port  out  PORT_W  selected input port
no_port  out  1  no port selected
beat_cnt  out  4  remaining beats in the current defined burst (debug/verification)

Behaviour:
- Interface: one clock HCLK. HRESET is synchronous and active-high. All state updates occur on posedge HCLK.
- Reset values: addr_in_port=0, no_port=1, beat_cnt=0, state=IDLE, rr_ptr=NUM_PORTS-1 (so port 0 wins first).
- All registers except the reset path update only when HREADYM=1. When HREADYM=0, every output and all state hold.
- Accepted beat: HREADYM & HSELM & (HTRANSM is NONSEQ or SEQ).
- Burst counter:
  - Accepted NONSEQ loads beat_cnt: WRAP4/INCR4 → 3, WRAP8/INCR8 → 7, WRAP16/INCR16 → 15, SINGLE/INCR → 0.
  - Accepted SEQ with beat_cnt>0 decrements it.
  - BUSY leaves it unchanged.
  - IDLE clears it.
- States:
  - IDLE: no_port=1.
  - OWNED: granted, free to re-arbitrate.
  - BURST: beat_cnt>0 after the update; grant frozen.
  - LOCKED: HMASTLOCKM=1; grant frozen.
- Next-grant priority when HREADYM=1, highest first:
  1. HMASTLOCKM=1 → keep owner, enter LOCKED.
  2. Next beat_cnt>0 → keep owner, enter BURST.
  3. Any req_port bit set → pick the first set bit searching from rr_ptr+1 upward, with modulo wrap. Set rr_ptr=winner, no_port=0, enter OWNED.
  4. No requests and HSELM=1 → keep owner, no_port=0 (park).
  5. Otherwise → no_port=1, addr_in_port unchanged, enter IDLE.
- rr_ptr changes only on a step-3 grant. A re-grant to the same port still updates it.
- Latency: grant is visible on addr_in_port one HCLK after the HREADYM=1 cycle that sampled the request.
- Simultaneous events:
  - Lock release (HMASTLOCKM falling) on the same cycle as pending requests → step 3 applies on that cycle.
  - A burst final beat on the same cycle as requests → re-arbitrate on that beat.
  - Early burst termination (NONSEQ/IDLE while beat_cnt>0) reloads or clears beat_cnt, then the priority rules apply.
- HRESET asserted mid-burst or mid-lock → reset values next edge regardless of HREADYM.

Optional Feature:
AHB_MTX_ARB_INCR_HOLD_EN
- Defined: an undefined-length INCR holds the grant while SEQ/BUSY continue.
  - Accepted NONSEQ INCR loads a hold counter with MAX_INCR_HOLD-1.
  - Hold is treated like beat_cnt>0 in step 2.
  - Counter reaching 0 forces re-arbitration.
- Undefined: INCR re-arbitrates on every beat (step 3 applies), and the hold counter logic is absent.

Decomposition:
- Package ahb_mtx_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HBURST encodings, arbiter state enum, burst-length-to-count constants.
- Sub-module rr_priority_pick: combinational rotating-priority one-hot/index selector (inputs: req vector, rr_ptr; outputs: winner index, any_req).

Test Plan:
- Reset: HRESET=1 for 2 cycles with requests present → addr_in_port=0, no_port=1, beat_cnt=0 while held; after release with req_port=0001 → addr_in_port=0, no_port=0 one cycle later.
- Round-robin: req_port=1111 held, single NONSEQ beats with HREADYM=1 → grant sequence 0,1,2,3,0.
- Burst hold: port 2 issues NONSEQ INCR8, port 0 requesting throughout → addr_in_port=2 for all 8 beats (beat_cnt 7→0); port 0 granted after the 8th beat.
- HREADYM stall: 3 wait states mid-burst with req change → addr_in_port and beat_cnt unchanged until HREADYM=1.
- Lock: port 1 HMASTLOCKM=1 over 4 SINGLE beats with req_port=1101 → grant stays 1; released on the HMASTLOCKM=0 cycle → port 2 next.
- Idle/park: req_port=0, HSELM=1, HTRANSM=IDLE → owner kept, no_port=0; then HSELM=0 → no_port=1. Also: HRESET mid-INCR16 at beat 5 → reset values next edge.
